// File: rtl/midi_message_decoder.sv
// MIDI byte-stream decoder: assembles channel-voice messages into a small output FIFO.
// Optional running status is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_message_decoder #(
    parameter int DATA_WIDTH = 7,
    parameter int CHANNEL_WIDTH = 4,
    parameter logic [(2**CHANNEL_WIDTH)-1:0] CHANNEL_MASK = '1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic [3:0]               msg_type,
    output logic [CHANNEL_WIDTH-1:0] msg_channel,
    output logic [DATA_WIDTH-1:0]    msg_data1,
    output logic [DATA_WIDTH-1:0]    msg_data2,
    output logic                     overflow,
    output logic                     protocol_error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 4 + CHANNEL_WIDTH + 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SKIP
    } state_t;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam state_t DONE_STATE = WAIT_D1;
`else
    localparam state_t DONE_STATE = IDLE;
`endif

    state_t                   r_state;
    state_t                   w_nextState;
    logic [3:0]               r_type;
    logic [3:0]               w_nextType;
    logic [CHANNEL_WIDTH-1:0] r_channel;
    logic [CHANNEL_WIDTH-1:0] w_nextChannel;
    logic [DATA_WIDTH-1:0]    r_data1;
    logic [DATA_WIDTH-1:0]    w_nextData1;
    logic                     w_complete;
    logic                     w_protoErr;
    logic [DATA_WIDTH-1:0]    w_msgData1;
    logic [DATA_WIDTH-1:0]    w_msgData2;
    logic [DATA_WIDTH-1:0]    w_dataField;
    logic                     w_isOneByte;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_protoErr;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_pushOk;
    logic [ENTRY_W-1:0] w_pushEntry;
    logic [ENTRY_W-1:0] w_head;

    assign w_dataField = DATA_WIDTH'(byte_data[6:0]);
    assign w_isOneByte = (r_type == 4'hC) || (r_type == 4'hD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_type    <= '0;
            r_channel <= '0;
            r_data1   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_type    <= w_nextType;
            r_channel <= w_nextChannel;
            r_data1   <= w_nextData1;
        end
    end

    // Real-time bytes (0xF8-0xFF) fall through every branch and leave all state untouched.
    always_comb begin
        w_nextState   = r_state;
        w_nextType    = r_type;
        w_nextChannel = r_channel;
        w_nextData1   = r_data1;
        w_complete    = 1'b0;
        w_protoErr    = 1'b0;
        w_msgData1    = '0;
        w_msgData2    = '0;
        if (byte_valid) begin
            if (byte_data[7]) begin
                if (byte_data[7:4] != 4'hF) begin
                    w_nextType    = byte_data[7:4];
                    w_nextChannel = byte_data[CHANNEL_WIDTH-1:0];
                    w_nextState   = WAIT_D1;
                end else if (!byte_data[3]) begin
                    w_nextState = SKIP;
                end
            end else begin
                case (r_state)
                    IDLE: w_protoErr = 1'b1;
                    WAIT_D1: begin
                        w_nextData1 = w_dataField;
                        if (w_isOneByte) begin
                            w_complete  = 1'b1;
                            w_msgData1  = w_dataField;
                            w_nextState = DONE_STATE;
                        end else begin
                            w_nextState = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        w_complete  = 1'b1;
                        w_msgData1  = r_data1;
                        w_msgData2  = w_dataField;
                        w_nextState = DONE_STATE;
                    end
                    default: w_nextState = r_state;
                endcase
            end
        end
    end

    assign w_push      = w_complete && CHANNEL_MASK[r_channel];
    assign w_pop       = msg_valid && msg_ready;
    assign w_full      = (r_count == FULL_COUNT);
    assign w_pushOk    = w_push && (!w_full || w_pop);
    assign w_pushEntry = {r_type, r_channel, w_msgData1, w_msgData2};

    always_ff @(posedge clock) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_protoErr <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            r_protoErr <= w_protoErr;
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_pushOk && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_pushOk && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign w_head         = r_mem[r_rdPtr];
    assign msg_valid      = (r_count != '0);
    assign {msg_type, msg_channel, msg_data1, msg_data2} = msg_valid ? w_head : '0;
    assign overflow       = r_overflow;
    assign protocol_error = r_protoErr;

endmodule

// File: tb/tb_midi_message_decoder.sv
// Self-checking bench for midi_message_decoder: directed literal cases plus randomized
// byte streams compared every cycle against a queue-based behavioural model.
module tb_midi_message_decoder;

    localparam int DEPTH = 4;
    localparam logic [15:0] MASK = 16'hFFFB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       msg_ready = 1'b0;
    logic       msg_valid;
    logic [3:0] msg_type;
    logic [3:0] msg_channel;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       overflow;
    logic       protocol_error;

    int checks = 0;
    int errors = 0;

    logic [21:0] expQ[$];
    int          mStatus = -1;
    bit          mSkip = 1'b0;
    int          mD1 = -1;
    bit          expOvf = 1'b0;
    bit          expErr = 1'b0;

    midi_message_decoder #(
        .DATA_WIDTH(7),
        .CHANNEL_WIDTH(4),
        .CHANNEL_MASK(MASK),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_type(msg_type),
        .msg_channel(msg_channel),
        .msg_data1(msg_data1),
        .msg_data2(msg_data2),
        .overflow(overflow),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A finished message is queued if its channel is accepted and there is room.
    function automatic void modelEmit(input int d1, input int d2);
        int ch;
        int typ;
        ch  = mStatus % 16;
        typ = mStatus / 16;
        mD1 = -1;
`ifndef MIDI_RUNNING_STATUS_EN
        mStatus = -1;
`endif
        if (MASK[ch]) begin
            if (expQ.size() < DEPTH) expQ.push_back({4'(typ), 4'(ch), 7'(d1), 7'(d2)});
            else expOvf = 1'b1;
        end
    endfunction

    function automatic void modelByte(input int b);
        int hi;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            mStatus = -1; mSkip = 1'b1; mD1 = -1;
        end else if (b >= 'h80) begin
            mStatus = b; mSkip = 1'b0; mD1 = -1;
        end else if (mStatus < 0) begin
            if (!mSkip) expErr = 1'b1;
        end else begin
            hi = mStatus / 16;
            if (hi == 12 || hi == 13) modelEmit(b, 0);
            else if (mD1 < 0) mD1 = b;
            else modelEmit(mD1, b);
        end
    endfunction

    // Model advances on each clock edge, then the DUT is compared just after it.
    always @(posedge clock) begin
        expOvf = 1'b0;
        expErr = 1'b0;
        if (reset) begin
            expQ.delete();
            mStatus = -1; mSkip = 1'b0; mD1 = -1;
        end else begin
            if (expQ.size() > 0 && msg_ready) void'(expQ.pop_front());
            if (byte_valid) modelByte(int'(byte_data));
        end
        #1;
        checkOutput("model msg_valid", msg_valid, expQ.size() > 0);
        if (expQ.size() > 0)
            checkOutput("model head", {msg_type, msg_channel, msg_data1, msg_data2}, expQ[0]);
        checkOutput("model overflow", overflow, expOvf);
        checkOutput("model protocol_error", protocol_error, expErr);
    end

    task automatic applyStimulus(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [7:0] randomByte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) return 8'(8'h80 + $urandom_range(0, 111));
        if (r < 19) return 8'(8'hF0 + $urandom_range(0, 7));
        if (r < 23) return 8'(8'hF8 + $urandom_range(0, 7));
        return 8'($urandom_range(0, 127));
    endfunction

    initial begin
        reset = 1'b1;
        idle(2);
        checkOutput("reset msg_valid", msg_valid, 0);
        checkOutput("reset fields", {msg_type, msg_channel, msg_data1, msg_data2}, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset protocol_error", protocol_error, 0);
        reset = 1'b0;
        msg_ready = 1'b1;
        idle(1);

        applyStimulus(8'h93); applyStimulus(8'h3C); applyStimulus(8'h64);
        checkOutput("note_on valid", msg_valid, 1);
        checkOutput("note_on head", {msg_type, msg_channel, msg_data1, msg_data2}, {4'h9, 4'h3, 7'h3C, 7'h64});
        idle(2);

        applyStimulus(8'h80); applyStimulus(8'h40); applyStimulus(8'h00);
        checkOutput("running first", {msg_type, msg_channel, msg_data1, msg_data2}, {4'h8, 4'h0, 7'h40, 7'h00});
        applyStimulus(8'h41);
`ifdef MIDI_RUNNING_STATUS_EN
        applyStimulus(8'h00);
        checkOutput("running second", {msg_type, msg_channel, msg_data1, msg_data2}, {4'h8, 4'h0, 7'h41, 7'h00});
`else
        checkOutput("no running error", protocol_error, 1);
        applyStimulus(8'h00);
        checkOutput("no running dropped", msg_valid, 0);
`endif
        idle(2);

        applyStimulus(8'hC5); applyStimulus(8'h07);
        checkOutput("program change", {msg_type, msg_channel, msg_data1, msg_data2}, {4'hC, 4'h5, 7'h07, 7'h00});
        idle(2);
        applyStimulus(8'hB1); applyStimulus(8'h15); applyStimulus(8'hF8); applyStimulus(8'h7F);
        checkOutput("realtime inside", {msg_type, msg_channel, msg_data1, msg_data2}, {4'hB, 4'h1, 7'h15, 7'h7F});
        idle(2);

        applyStimulus(8'hF0); applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'hF7);
        applyStimulus(8'h90); applyStimulus(8'h30); applyStimulus(8'h40);
        checkOutput("after sysex", {msg_type, msg_channel, msg_data1, msg_data2}, {4'h9, 4'h0, 7'h30, 7'h40});
        idle(2);
        applyStimulus(8'h92); applyStimulus(8'h30); applyStimulus(8'h40);
        checkOutput("masked channel", msg_valid, 0);
        idle(2);

        msg_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'hC4 + i)); applyStimulus(8'(i + 1));
        end
        checkOutput("overflow pulse", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fifo order", {msg_type, msg_channel, msg_data1, msg_data2},
                        {4'hC, 4'(4 + i), 7'(i + 1), 7'h00});
            msg_ready = 1'b1;
            @(negedge clock);
            msg_ready = 1'b0;
        end
        checkOutput("fifo drained", msg_valid, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(8'hC4 + i)); applyStimulus(8'(i + 1));
        end
        applyStimulus(8'hC9);
        msg_ready = 1'b1;
        applyStimulus(8'h55);
        msg_ready = 1'b0;
        checkOutput("pop and push overflow", overflow, 0);
        checkOutput("pop and push head", {msg_type, msg_channel, msg_data1, msg_data2}, {4'hC, 4'h5, 7'h02, 7'h00});
        msg_ready = 1'b1;
        idle(6);

        msg_ready = 1'b0;
        applyStimulus(8'hC4); applyStimulus(8'h01); applyStimulus(8'hC5); applyStimulus(8'h02);
        applyStimulus(8'h90); applyStimulus(8'h30);
        reset = 1'b1;
        #1;
        checkOutput("async reset valid", msg_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(8'h40);
        checkOutput("post reset error", protocol_error, 1);
        checkOutput("post reset no msg", msg_valid, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_data  = randomByte();
            msg_ready  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            @(negedge clock);
        end
        byte_valid = 1'b0;
        msg_ready  = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
